video_dark_pipe: RTL

- Parametrised successor to the fixed two-register HDMI middle buffer between the SiI9013 receiver and the ADV7511 transmitter.
- Delays hs/vs/de/data by a configurable number of vin_clk cycles, all signals kept aligned.
- Applies a per-frame-selected pixel transform: bypass, invert, per-pixel threshold invert, or whole-frame "dark mode" invert.
- Whole-frame mode inverts a frame when most active pixels of the previous frame were bright.

---
 rtl/video_dark_pipe.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/video_dark_pipe.sv
// Aligned hs/vs/de/data delay line with a per-frame pixel transform
// (bypass, invert, whole-frame dark-mode invert, per-pixel threshold invert).
module video_dark_pipe #(
  parameter int unsigned CW    = 8,
  parameter int unsigned CH    = 3,
  parameter int unsigned DELAY = 2,
  parameter int unsigned CNT_W = 24
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [1:0]         mode_i,
  input  logic [CW-1:0]      thres_i,
  input  logic               vin_hs_i,
  input  logic               vin_vs_i,
  input  logic               vin_de_i,
  input  logic [CH*CW-1:0]   vin_data_i,
  output logic               vout_hs_o,
  output logic               vout_vs_o,
  output logic               vout_de_o,
  output logic [CH*CW-1:0]   vout_data_o,
  output logic               frame_dark_o,
  output logic [1:0]         mode_o
);

  localparam int unsigned DW = CH * CW;

  typedef enum logic [1:0] {
    MODE_BYPASS     = 2'd0,
    MODE_INVERT     = 2'd1,
    MODE_FRAME_DARK = 2'd2,
    MODE_PIX_THRES  = 2'd3
  } mode_e;

  mode_e            mode_q, mode_d;
  logic             vs_prev_q, vs_prev_d;
  logic             frame_dark_q, frame_dark_d;
  logic [CNT_W-1:0] act_cnt_q, act_cnt_d;
  logic [CNT_W-1:0] bright_cnt_q, bright_cnt_d;

  logic [DELAY-1:0] hs_pipe_q, hs_pipe_d;
  logic [DELAY-1:0] vs_pipe_q, vs_pipe_d;
  logic [DELAY-1:0] de_pipe_q, de_pipe_d;
  logic [DW-1:0]    data_pipe_q [DELAY];
  logic [DW-1:0]    data_pipe_d [DELAY];

  logic [CW-1:0]    max_chan;
  logic             bright;
  logic             fe;
  logic             invert_en;
  logic [DW-1:0]    data_xf;

  always_comb begin
    max_chan = '0;
    for (int unsigned k = 0; k < CH; k++) begin
      if (vin_data_i[k*CW +: CW] > max_chan) max_chan = vin_data_i[k*CW +: CW];
    end
  end

  assign bright = (max_chan >= thres_i);
  assign fe     = vin_vs_i & ~vs_prev_q;

  // Frame statistics: a de pixel in the fe cycle is the first pixel of the new frame.
  always_comb begin
    vs_prev_d    = vin_vs_i;
    mode_d       = mode_q;
    frame_dark_d = frame_dark_q;
    act_cnt_d    = act_cnt_q;
    bright_cnt_d = bright_cnt_q;
    if (fe) begin
      mode_d       = mode_e'(mode_i);
      frame_dark_d = (bright_cnt_q > (act_cnt_q >> 1));
      act_cnt_d    = CNT_W'(vin_de_i);
      bright_cnt_d = CNT_W'(vin_de_i & bright);
    end else if (vin_de_i) begin
      if (act_cnt_q != '1) act_cnt_d = act_cnt_q + 1'b1;
      if (bright && (bright_cnt_q != '1)) bright_cnt_d = bright_cnt_q + 1'b1;
    end
  end

  // Uses the held (pre-fe) mode and dark decision for the pixel entering now.
  always_comb begin
    invert_en = 1'b0;
    unique case (mode_q)
      MODE_BYPASS:     invert_en = 1'b0;
      MODE_INVERT:     invert_en = 1'b1;
      MODE_FRAME_DARK: invert_en = frame_dark_q;
      MODE_PIX_THRES:  invert_en = bright;
      default:         invert_en = 1'b0;
    endcase
    data_xf = invert_en ? ~vin_data_i : vin_data_i;
  end

  always_comb begin
    hs_pipe_d      = '0;
    vs_pipe_d      = '0;
    de_pipe_d      = '0;
    data_pipe_d[0] = data_xf;
    hs_pipe_d[0]   = vin_hs_i;
    vs_pipe_d[0]   = vin_vs_i;
    de_pipe_d[0]   = vin_de_i;
    for (int unsigned i = 1; i < DELAY; i++) begin
      hs_pipe_d[i]   = hs_pipe_q[i-1];
      vs_pipe_d[i]   = vs_pipe_q[i-1];
      de_pipe_d[i]   = de_pipe_q[i-1];
      data_pipe_d[i] = data_pipe_q[i-1];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mode_q       <= MODE_BYPASS;
      vs_prev_q    <= 1'b0;
      frame_dark_q <= 1'b0;
      act_cnt_q    <= '0;
      bright_cnt_q <= '0;
      hs_pipe_q    <= '0;
      vs_pipe_q    <= '0;
      de_pipe_q    <= '0;
      for (int unsigned i = 0; i < DELAY; i++) data_pipe_q[i] <= '0;
    end else begin
      mode_q       <= mode_d;
      vs_prev_q    <= vs_prev_d;
      frame_dark_q <= frame_dark_d;
      act_cnt_q    <= act_cnt_d;
      bright_cnt_q <= bright_cnt_d;
      hs_pipe_q    <= hs_pipe_d;
      vs_pipe_q    <= vs_pipe_d;
      de_pipe_q    <= de_pipe_d;
      for (int unsigned i = 0; i < DELAY; i++) data_pipe_q[i] <= data_pipe_d[i];
    end
  end

  assign vout_hs_o    = hs_pipe_q[DELAY-1];
  assign vout_vs_o    = vs_pipe_q[DELAY-1];
  assign vout_de_o    = de_pipe_q[DELAY-1];
  assign vout_data_o  = data_pipe_q[DELAY-1];
  assign frame_dark_o = frame_dark_q;
  assign mode_o       = mode_q;

endmodule
